// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus: instruction memory port, EX redirect, IF/ID hand-off and PC observation.
// master = fetch stage, slave = the surrounding core (memory, EX, ID).
interface if_fetch_stage_if #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned IMEM_AW = 11
);
    logic               imem_req;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rdata;
    logic               redirect_valid;
    logic [XLEN-1:0]    redirect_pc;
    logic               id_ready;
    logic               if_id_valid;
    logic [XLEN-1:0]    if_id_pc;
    logic [31:0]        if_id_instruction;
    logic [XLEN-1:0]    pc_reg;

    // IF/ID hand-off: a word transfers on a cycle where if_id_valid & id_ready;
    // while id_ready is low the IF/ID contents are held stable.
    modport master (
        output imem_req, imem_addr, if_id_valid, if_id_pc, if_id_instruction, pc_reg,
        input  imem_rdata, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_id_valid, if_id_pc, if_id_instruction, pc_reg,
        output imem_rdata, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/if_fetch_stage.sv
// RV32I instruction fetch: PC register, single-outstanding synchronous IMEM read,
// IF/ID register backed by a one-entry skid buffer, EX redirect flush.
module if_fetch_stage #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int unsigned     IMEM_AW   = 11,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input logic              clk,
    input logic              rst,
    if_fetch_stage_if.master bus
);
    logic [XLEN-1:0] pc_q, pc_d;
    logic            if_id_valid_q, if_id_valid_d;
    logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;
    logic [31:0]     if_id_instr_q, if_id_instr_d;
    logic            skid_valid_q, skid_valid_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;
    logic [31:0]     skid_instr_q, skid_instr_d;
    logic            inflight_q, inflight_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;

    logic            pop;
    logic            issue;
    logic [1:0]      owed;
    logic [XLEN-1:0] redirect_aligned;

    assign pop              = if_id_valid_q & bus.id_ready;
    assign redirect_aligned = bus.redirect_pc & ~XLEN'(3);

    // Words already owed to ID (buffered + in memory) after this cycle's pop; never exceeds 2.
    assign owed  = {1'b0, if_id_valid_q} + {1'b0, skid_valid_q} + {1'b0, inflight_q} - {1'b0, pop};
    assign issue = rst & ~bus.redirect_valid & (owed < 2'd2);

    assign bus.imem_req          = issue;
    assign bus.imem_addr         = pc_q[IMEM_AW-1:0];
    assign bus.pc_reg            = pc_q;
    assign bus.if_id_valid       = if_id_valid_q;
    assign bus.if_id_pc          = if_id_pc_q;
    assign bus.if_id_instruction = if_id_instr_q;

    always_comb begin
        pc_d          = pc_q;
        if_id_valid_d = if_id_valid_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        skid_valid_d  = skid_valid_q;
        skid_pc_d     = skid_pc_q;
        skid_instr_d  = skid_instr_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;

        if (bus.redirect_valid) begin
            // The response returning now and any request from before are dropped.
            pc_d          = redirect_aligned;
            if_id_valid_d = 1'b0;
            if_id_instr_d = NOP_INSTR;
            skid_valid_d  = 1'b0;
            inflight_d    = 1'b0;
        end else begin
            inflight_d    = issue;
            inflight_pc_d = pc_q;
            if (issue) begin
                pc_d = pc_q + XLEN'(4);
            end

            if (pop && skid_valid_q) begin
                if_id_valid_d = 1'b1;
                if_id_pc_d    = skid_pc_q;
                if_id_instr_d = skid_instr_q;
                skid_valid_d  = inflight_q;
                skid_pc_d     = inflight_pc_q;
                skid_instr_d  = bus.imem_rdata;
            end else if (inflight_q && (!if_id_valid_q || pop)) begin
                if_id_valid_d = 1'b1;
                if_id_pc_d    = inflight_pc_q;
                if_id_instr_d = bus.imem_rdata;
            end else if (inflight_q) begin
                skid_valid_d  = 1'b1;
                skid_pc_d     = inflight_pc_q;
                skid_instr_d  = bus.imem_rdata;
            end else if (pop) begin
                if_id_valid_d = 1'b0;
                if_id_instr_d = NOP_INSTR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q          <= RESET_PC;
            if_id_valid_q <= 1'b0;
            if_id_pc_q    <= '0;
            if_id_instr_q <= NOP_INSTR;
            skid_valid_q  <= 1'b0;
            skid_pc_q     <= '0;
            skid_instr_q  <= NOP_INSTR;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            pc_q          <= pc_d;
            if_id_valid_q <= if_id_valid_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            skid_valid_q  <= skid_valid_d;
            skid_pc_q     <= skid_pc_d;
            skid_instr_q  <= skid_instr_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end
endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus randomized stall/redirect/reset traffic,
// checked every cycle against a count-and-queue model of the fetch stream.
module tb_if_fetch_stage;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk;
    logic rst;

    if_fetch_stage_if #(.XLEN(32), .IMEM_AW(32)) bus ();

    if_fetch_stage #(
        .XLEN(32), .RESET_PC(RESET_PC), .IMEM_AW(32), .NOP_INSTR(NOP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous-read memory: word[i] = i; garbage when not requested.
    always @(posedge clk) begin
        bus.imem_rdata <= bus.imem_req ? {2'b00, bus.imem_addr[31:2]} : 32'hDEAD_BEEF;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: exp_q holds every address requested since the last flush that ID
    // has not yet consumed, oldest first; m_in_mem marks that the newest is still in memory.
    logic [31:0] exp_q[$];
    logic [31:0] m_pc;
    bit          m_known = 0;
    bit          m_in_mem;
    bit          m_post_reset;

    always @(negedge clk) begin
        bit exp_valid, exp_pop, exp_req;
        int owed;
        if (!rst) begin
            check_eq("req_in_reset", {31'b0, bus.imem_req}, 32'd0);
            m_known      = 1;
            m_in_mem     = 0;
            m_post_reset = 1;
            m_pc         = RESET_PC;
            exp_q.delete();
        end else if (m_known) begin
            owed      = exp_q.size();
            exp_valid = (owed - (m_in_mem ? 1 : 0)) > 0;
            check_eq("if_id_valid", {31'b0, bus.if_id_valid}, {31'b0, exp_valid});
            check_eq("pc_reg", bus.pc_reg, m_pc);
            check_eq("imem_addr", bus.imem_addr, m_pc);
            if (m_post_reset) check_eq("if_id_pc_after_reset", bus.if_id_pc, 32'd0);
            m_post_reset = 0;
            if (exp_valid) begin
                check_eq("if_id_pc", bus.if_id_pc, exp_q[0]);
                check_eq("if_id_instr", bus.if_id_instruction, exp_q[0] >> 2);
            end else begin
                check_eq("nop_when_invalid", bus.if_id_instruction, NOP);
            end
            exp_pop = exp_valid && bus.id_ready;
            exp_req = !bus.redirect_valid && ((owed - (exp_pop ? 1 : 0)) < 2);
            check_eq("imem_req", {31'b0, bus.imem_req}, {31'b0, exp_req});
            if (bus.redirect_valid) begin
                exp_q.delete();
                m_in_mem = 0;
                m_pc     = bus.redirect_pc & ~32'h3;
            end else begin
                if (exp_pop) void'(exp_q.pop_front());
                if (exp_req) begin
                    exp_q.push_back(m_pc);
                    m_pc = m_pc + 32'd4;
                end
                m_in_mem = exp_req;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
        @(posedge clk);
        #1;
        rst                = r;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.id_ready       = rdy;
    endtask

    task automatic run(input int n, input logic rdy);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 32'h0, rdy);
    endtask

    task automatic redirect(input logic [31:0] target, input logic rdy);
        drive(1'b1, 1'b1, target, rdy);
    endtask

    initial begin
        rst                = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.id_ready       = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 1'b1);

        // Startup, then stall with pc 8 in IF/ID, then release.
        run(4, 1'b1);
        run(4, 1'b0);
        run(6, 1'b1);

        // Redirect to 0x40 while the pc-0x10 request is in flight.
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        run(5, 1'b1);
        redirect(32'h40, 1'b1);
        run(5, 1'b1);

        // Misaligned target, then redirect during a stall, then back-to-back redirects.
        redirect(32'h43, 1'b1);
        run(4, 1'b1);
        run(3, 1'b0);
        redirect(32'h100, 1'b0);
        run(4, 1'b0);
        run(3, 1'b1);
        redirect(32'h200, 1'b1);
        redirect(32'h300, 1'b1);
        run(5, 1'b1);

        // Reset mid-stream with IF/ID and skid full.
        run(3, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        run(6, 1'b1);

        // PC wrap at the top of the address space.
        redirect(32'hFFFF_FFFC, 1'b1);
        run(5, 1'b1);
        redirect(32'hFFFF_FFF8, 1'b0);
        run(3, 1'b0);
        run(5, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            logic r, rv, rdy;
            logic [31:0] rpc;
            r   = ($urandom_range(0, 99) != 0);
            rv  = ($urandom_range(0, 15) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom();
            drive(r, rv, rpc, rdy);
        end

        run(4, 1'b1);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
